w_converge_check: RTL and testbench

- Consumer end of the W-matrix feedback path: the decision stage writes a 4x4 Q13.13 unmixing matrix, and this block reads it after each FastICA iteration.
- Per iteration it captures the 16 words, scans them one element per cycle against the previous iteration's snapshot, and finds the maximum absolute element difference.
- It then reports converged, not converged, or iteration timeout to the top-level sequencer.

---
 rtl/w_converge_check.sv | 145 ++++++++++++++
 tb/tb_w_converge_check.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/w_converge_check.sv
// w_converge_check
//   Consumer end of the W-matrix feedback path. Each FastICA iteration it
//   captures a 4x4 signed W matrix. It then scans the matrix one element per
//   cycle against the previous snapshot and finds the maximum absolute element
//   difference. Finally it reports converged / not converged / timeout.
//
//   Optional feature, enabled by defining SIGN_FOLD_EN:
//     A second running maximum of |new + old| is kept. The smaller of the two
//     maxima is used, so W and -W count as the same solution.
//
// Ports
//   clk_c        rising-edge clock
//   rst_c        synchronous active-high reset
//   start_c      new W present on iw11..iw44; sampled only in IDLE
//   iw11..iw44   signed W elements, row-major, WIDTH bits, valid with start_c
//   busy_c       high from the cycle after start is accepted through done_c
//   done_c       one-cycle pulse when the decision outputs update
//   converged_c  decision flag, held until the next done_c or reset
//   timeout_c    sticky: MAX_ITER iterations reached without convergence
//   iter_cnt     completed iterations, saturating at MAX_ITER
//   max_diff     unsigned maximum absolute difference of the last scan
module w_converge_check #(
  parameter int WIDTH    = 26,
  parameter int TOL      = 8,
  parameter int MAX_ITER = 64
) (
  input  logic             clk_c,
  input  logic             rst_c,
  input  logic             start_c,
  input  logic [WIDTH-1:0] iw11, iw12, iw13, iw14,
  input  logic [WIDTH-1:0] iw21, iw22, iw23, iw24,
  input  logic [WIDTH-1:0] iw31, iw32, iw33, iw34,
  input  logic [WIDTH-1:0] iw41, iw42, iw43, iw44,
  output logic             busy_c,
  output logic             done_c,
  output logic             converged_c,
  output logic             timeout_c,
  output logic [6:0]       iter_cnt,
  output logic [WIDTH:0]   max_diff
);

  typedef enum logic [1:0] {IDLE, SCAN, DECIDE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] iw_all [16];
  logic [WIDTH-1:0] new_w  [16];
  logic [WIDTH-1:0] old_w  [16];
  logic [3:0]       idx;
  logic [WIDTH:0]   new_ext, old_ext, diff, d, max_d, max_sel;
  logic [6:0]       iter_inc;
  logic             accept, conv_now;
`ifdef SIGN_FOLD_EN
  logic [WIDTH:0]   sum, s, max_s;
`endif

  assign iw_all = '{iw11, iw12, iw13, iw14, iw21, iw22, iw23, iw24,
                    iw31, iw32, iw33, iw34, iw41, iw42, iw43, iw44};

  assign accept   = (state == IDLE) && start_c && !timeout_c;
  assign busy_c   = (state != IDLE) || done_c;
  assign iter_inc = iter_cnt + 7'd1;

  // Sign-extend to WIDTH+1 before subtracting so full-scale opposite signs
  // cannot overflow; the magnitude then always fits unsigned in WIDTH+1.
  always_comb begin
    new_ext = {new_w[idx][WIDTH-1], new_w[idx]};
    old_ext = {old_w[idx][WIDTH-1], old_w[idx]};
    diff    = new_ext - old_ext;
    d       = diff[WIDTH] ? -diff : diff;
`ifdef SIGN_FOLD_EN
    sum     = new_ext + old_ext;
    s       = sum[WIDTH] ? -sum : sum;
    max_sel = (max_s < max_d) ? max_s : max_d;
`else
    max_sel = max_d;
`endif
    conv_now = (iter_cnt != 7'd0) && (max_sel <= (WIDTH+1)'(TOL));
  end

  always_ff @(posedge clk_c) begin
    if (rst_c) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SCAN;
      SCAN:    if (idx == 4'd15) state_nxt = DECIDE;
      DECIDE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_c) begin
    if (rst_c) begin
      done_c      <= 1'b0;
      converged_c <= 1'b0;
      timeout_c   <= 1'b0;
      iter_cnt    <= '0;
      max_diff    <= '0;
      max_d       <= '0;
      idx         <= '0;
`ifdef SIGN_FOLD_EN
      max_s       <= '0;
`endif
      for (int unsigned i = 0; i < 16; i++) begin
        new_w[i] <= '0;
        old_w[i] <= '0;
      end
    end else begin
      done_c <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            for (int unsigned i = 0; i < 16; i++) new_w[i] <= iw_all[i];
            max_d <= '0;
            idx   <= '0;
`ifdef SIGN_FOLD_EN
            max_s <= '0;
`endif
          end
        end
        SCAN: begin
          // Strict compare: a tie keeps the current maximum.
          if (d > max_d) max_d <= d;
`ifdef SIGN_FOLD_EN
          if (s > max_s) max_s <= s;
`endif
          idx <= idx + 4'd1;
        end
        DECIDE: begin
          max_diff    <= max_sel;
          converged_c <= conv_now;
          for (int unsigned i = 0; i < 16; i++) old_w[i] <= new_w[i];
          if (iter_cnt < 7'(MAX_ITER)) iter_cnt <= iter_inc;
          if ((iter_inc == 7'(MAX_ITER)) && !conv_now) timeout_c <= 1'b1;
          done_c <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_w_converge_check.sv
// Testbench for w_converge_check: table of W vectors with expected decisions,
// a scoreboard queue filled at start and drained on done_c, and hand-written
// sequences for reset, ignored starts, mid-scan abort and timeout.
module tb_w_converge_check;

  logic              clk_c = 1'b0;
  logic              rst_c;
  logic              start_c;
  logic [15:0][25:0] cur_w;
  logic              busy_c, done_c, converged_c, timeout_c;
  logic [6:0]        iter_cnt;
  logic [26:0]       max_diff;

  typedef struct packed {
    logic        conv;
    logic        to;
    logic [6:0]  it;
    logic [26:0] md;
  } exp_t;

  typedef struct {
    logic [15:0][25:0] w;
    exp_t              e;
    bit                poke;
  } vec_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  w_converge_check #(.WIDTH(26), .TOL(8), .MAX_ITER(64)) dut (
    .clk_c(clk_c), .rst_c(rst_c), .start_c(start_c),
    .iw11(cur_w[0]),  .iw12(cur_w[1]),  .iw13(cur_w[2]),  .iw14(cur_w[3]),
    .iw21(cur_w[4]),  .iw22(cur_w[5]),  .iw23(cur_w[6]),  .iw24(cur_w[7]),
    .iw31(cur_w[8]),  .iw32(cur_w[9]),  .iw33(cur_w[10]), .iw34(cur_w[11]),
    .iw41(cur_w[12]), .iw42(cur_w[13]), .iw43(cur_w[14]), .iw44(cur_w[15]),
    .busy_c(busy_c), .done_c(done_c), .converged_c(converged_c),
    .timeout_c(timeout_c), .iter_cnt(iter_cnt), .max_diff(max_diff)
  );

  initial forever #5 clk_c = ~clk_c;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input bit conv, input bit to, input int it, input longint md);
    exp_t e;
    e.conv = conv;
    e.to   = to;
    e.it   = 7'(it);
    e.md   = 27'(md);
    return e;
  endfunction

  // Scoreboard: compare decision outputs on each done_c pulse.
  always @(negedge clk_c) begin
    if (done_c) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("converged_c", converged_c, e.conv);
        chk("timeout_c", timeout_c, e.to);
        chk("iter_cnt", iter_cnt, e.it);
        chk("max_diff", max_diff, e.md);
      end
    end
  end

  // Called at a negedge; returns at the negedge of the done_c cycle so the
  // next call drives start_c in that cycle (back-to-back iterations).
  task automatic run_iter(input logic [15:0][25:0] w, input exp_t e, input bit poke);
    bit seen;
    int busy_cnt;
    seen     = 0;
    busy_cnt = 0;
    cur_w    = w;
    start_c  = 1'b1;
    q.push_back(e);
    for (int n = 1; n <= 40 && !seen; n++) begin
      @(negedge clk_c);
      if (n == 1) start_c = 1'b0;
      if (poke && n == 5) begin cur_w = ~w; start_c = 1'b1; end
      if (poke && n == 6) start_c = 1'b0;
      if (busy_c) busy_cnt++;
      if (done_c) begin
        seen = 1;
        chk("done_latency", n, 18);
        chk("busy_cycles", busy_cnt, 18);
      end
    end
    if (!seen) chk("done_wait_expired", 0, 1);
  endtask

  int                base_i [16] = '{-1223, 100, -200, 300, -50, 800, 17, -1000,
                                     64, -512, 1000, 0, -7, 256, -333, 3612};
  logic [15:0][25:0] base_w, wa, wb, wk;
  vec_t              tbl [8];
  int                busy_seen;

  initial begin
    for (int i = 0; i < 16; i++) base_w[i] = 26'(base_i[i]);
    wa = base_w;
    tbl[0] = '{w: wa, e: mk(0, 0, 1, 'hE1C), poke: 0};
    tbl[1] = '{w: wa, e: mk(1, 0, 2, 0), poke: 1};
    wa[9] = wa[9] + 26'd8;            // w32 +8 LSB: exactly TOL
    tbl[2] = '{w: wa, e: mk(1, 0, 3, 8), poke: 0};
    wa[12] = wa[12] - 26'd9;          // w41 -9 LSB: just over TOL
    tbl[3] = '{w: wa, e: mk(0, 0, 4, 9), poke: 0};
    wb = wa;
    wb[0] = 26'h1FFFFFF;
`ifdef SIGN_FOLD_EN
    tbl[4] = '{w: wb, e: mk(0, 0, 5, 'h1FFFB38), poke: 0};
`else
    tbl[4] = '{w: wb, e: mk(0, 0, 5, 'h20004C6), poke: 0};
`endif
    wb[0] = 26'h2000000;              // full-scale opposite sign: no wrap
`ifdef SIGN_FOLD_EN
    tbl[5] = '{w: wb, e: mk(0, 0, 6, 'h1C38), poke: 0};
    tbl[6] = '{w: wa, e: mk(0, 0, 7, 'h1FFFB39), poke: 0};
`else
    tbl[5] = '{w: wb, e: mk(0, 0, 6, 'h3FFFFFF), poke: 0};
    tbl[6] = '{w: wa, e: mk(0, 0, 7, 'h1FFFB39), poke: 0};
`endif
    for (int i = 0; i < 16; i++) wb[i] = -wa[i];
`ifdef SIGN_FOLD_EN
    tbl[7] = '{w: wb, e: mk(1, 0, 8, 0), poke: 0};
`else
    tbl[7] = '{w: wb, e: mk(0, 0, 8, 'h1C38), poke: 0};
`endif

    // Reset with a start pulse present: nothing is accepted.
    rst_c   = 1'b1;
    start_c = 1'b1;
    cur_w   = base_w;
    repeat (3) @(negedge clk_c);
    chk("rst_busy", busy_c, 0);
    chk("rst_done", done_c, 0);
    chk("rst_conv", converged_c, 0);
    chk("rst_timeout", timeout_c, 0);
    chk("rst_iter", iter_cnt, 0);
    chk("rst_maxdiff", max_diff, 0);
    rst_c   = 1'b0;
    start_c = 1'b0;
    repeat (3) @(negedge clk_c);
    chk("post_rst_busy", busy_c, 0);

    for (int i = 0; i < 8; i++) run_iter(tbl[i].w, tbl[i].e, tbl[i].poke);

    // Iterations 9..64: every element moves by more than TOL.
    for (int k = 9; k <= 64; k++) begin
      for (int i = 0; i < 16; i++) wk[i] = wa[i] + 26'(k * 16);
      if (k == 9) begin
`ifdef SIGN_FOLD_EN
        run_iter(wk, mk(0, 0, 9, 144), 0);
`else
        run_iter(wk, mk(0, 0, 9, 'h1CC8), 0);
`endif
      end else begin
        run_iter(wk, mk(0, k == 64, k, 16), 0);
      end
    end

    // Timed out: start_c is ignored.
    @(negedge clk_c);
    cur_w     = base_w;
    start_c   = 1'b1;
    busy_seen = 0;
    for (int n = 0; n < 22; n++) begin
      @(negedge clk_c);
      start_c = 1'b0;
      if (busy_c) busy_seen++;
    end
    chk("timeout_busy", busy_seen, 0);
    chk("timeout_sticky", timeout_c, 1);
    chk("timeout_iter", iter_cnt, 64);

    // Reset clears timeout; then a reset mid-scan aborts with no done_c.
    rst_c = 1'b1;
    @(negedge clk_c);
    rst_c   = 1'b0;
    start_c = 1'b1;
    @(negedge clk_c);
    start_c = 1'b0;
    repeat (4) @(negedge clk_c);
    chk("midscan_busy", busy_c, 1);
    rst_c = 1'b1;
    @(negedge clk_c);
    rst_c     = 1'b0;
    busy_seen = 0;
    for (int n = 0; n < 22; n++) begin
      @(negedge clk_c);
      if (busy_c) busy_seen++;
    end
    chk("abort_busy", busy_seen, 0);
    chk("abort_iter", iter_cnt, 0);
    chk("abort_timeout", timeout_c, 0);

    // Snapshot was cleared by reset: first iteration compares against zero.
    run_iter(base_w, mk(0, 0, 1, 'hE1C), 0);
    repeat (3) @(negedge clk_c);
    chk("scoreboard_empty", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
